// File: rtl/mem_access_pkg.sv
// Shared types for the memory-access stage.
//   msize_t : access size encoding (byte / half / word, 3 reserved)
//   state_e : mem_access FSM states
//   strb_t  : 4-bit byte-lane strobe
//   access_err() : flags misaligned addresses and the reserved size
package mem_access_pkg;

  typedef enum logic [1:0] {
    MSIZE_B = 2'd0,
    MSIZE_H = 2'd1,
    MSIZE_W = 2'd2
  } msize_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } state_e;

  typedef logic [3:0] strb_t;

  // 1 when the access cannot be issued on the bus: halfword on an odd byte,
  // word not on a 4-byte boundary, or the reserved size code.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
    logic err;
    case (size)
      2'd0:    err = 1'b0;
      2'd1:    err = off[0];
      2'd2:    err = (off != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment for the memory-access stage (purely combinational).
//   size_i     : access size (msize_t encoding)
//   off_i      : byte offset within the word (addr[1:0])
//   unsigned_i : zero-extend sub-word loads when 1
//   wdata_i    : store data, low-aligned
//   rdata_i    : bus word containing the addressed bytes
//   strobe_o   : byte-lane enables for the bus
//   wdata_o    : store data replicated across all lanes
//   rdata_o    : load data shifted down and sign/zero-extended
module mem_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output strb_t       strobe_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] lane;
  logic        sign_b;
  logic        sign_h;

  always_comb begin
    lane   = rdata_i >> {off_i, 3'b000};
    sign_b = ~unsigned_i & lane[7];
    sign_h = ~unsigned_i & lane[15];
    case (size_i)
      2'd0: begin
        strobe_o = strb_t'(4'b0001 << off_i);
        wdata_o  = {4{wdata_i[7:0]}};
        rdata_o  = {{24{sign_b}}, lane[7:0]};
      end
      2'd1: begin
        strobe_o = strb_t'(4'b0011 << off_i);
        wdata_o  = {2{wdata_i[15:0]}};
        rdata_o  = {{16{sign_h}}, lane[15:0]};
      end
      default: begin
        strobe_o = 4'b1111;
        wdata_o  = wdata_i;
        rdata_o  = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-stage load/store unit: accepts one request, drives a simple
// req/ack data bus, and returns one completion pulse with aligned data.
//   clk, resetn          : clock, synchronous active-low reset
//   req_*                : request from the pipeline (valid/write/addr/wdata/size/unsigned)
//   req_ready            : high only in idle; accept = req_valid & req_ready
//   stall                : freeze upstream while a request is pending
//   resp_valid/rdata/err : one-cycle completion
//   dbus_*               : data bus, word-aligned address, held stable until ack
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              req_ready,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              dbus_req,
  output logic              dbus_wen,
  output logic [ADDR_W-1:0] dbus_addr,
  output strb_t             dbus_strobe,
  output logic [31:0]       dbus_wdata,
  input  logic              dbus_ack,
  input  logic [31:0]       dbus_rdata
);

  localparam int unsigned CntW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] LastWait = CntW'(MAX_WAIT - 1);

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  strb_t       al_strobe;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            write_q    <= req_write;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            rdata_q    <= '0;
            cnt_q      <= '0;
            // Illegal accesses skip the bus and report straight away.
            if (access_err(req_size, req_addr[1:0])) begin
              err_q   <= 1'b1;
              state_q <= StResp;
            end else begin
              err_q   <= 1'b0;
              state_q <= StBusy;
            end
          end
        end
        StBusy: begin
          // Ack takes priority over a timeout in the same cycle.
          if (dbus_ack) begin
            rdata_q <= dbus_rdata;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            state_q <= StResp;
          end else if (cnt_q == LastWait) begin
            cnt_q   <= '0;
            err_q   <= 1'b1;
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  mem_align u_align (
    .size_i     (size_q),
    .off_i      (addr_q[1:0]),
    .unsigned_i (unsigned_q),
    .wdata_i    (wdata_q),
    .rdata_i    (rdata_q),
    .strobe_o   (al_strobe),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata)
  );

  logic is_idle;
  logic is_busy;
  logic is_resp;

  always_comb begin
    is_idle     = (state_q == StIdle);
    is_busy     = (state_q == StBusy);
    is_resp     = (state_q == StResp);
    req_ready   = is_idle;
    // Low in the response cycle so the pipeline advances once per completion.
    stall       = (is_idle & req_valid) | is_busy;
    resp_valid  = is_resp;
    resp_err    = is_resp & err_q;
    resp_rdata  = (is_resp & ~err_q & ~write_q) ? al_rdata : 32'h0;
    dbus_req    = is_busy;
    dbus_wen    = is_busy & write_q;
    dbus_addr   = is_busy ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    dbus_strobe = is_busy ? al_strobe : 4'b0000;
    dbus_wdata  = is_busy ? al_wdata : 32'h0;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255, bus-ack cycles waited before timeout error.
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 resetn  in  1  synchronous active-low reset.
REQ-006 req_valid  in  1  memory-stage load/store request present.
REQ-007 req_write  in  1  1=store, 0=load.
REQ-008 req_addr  in  ADDR_W  byte address (memory-stage ALU result).
REQ-009 req_wdata  in  32  store data (memory-stage write data).
REQ-010 req_size  in  2  msize_t: byte / half / word.
REQ-011 req_unsigned  in  1  zero-extend load when 1.
REQ-012 req_ready  out  1  request accepted this cycle.
REQ-013 stall  out  1  freeze upstream pipeline registers.
REQ-014 resp_valid  out  1  one-cycle completion pulse.
REQ-015 resp_rdata  out  32  aligned, extended load data; 0 for stores and errors.
REQ-016 resp_err  out  1  misaligned, reserved size, or timeout; valid with resp_valid.
REQ-017 dbus_req, dbus_wen  out  1 each; dbus_addr  out  ADDR_W  word-aligned; dbus_strobe  out  4; dbus_wdata  out  32.
REQ-018 dbus_ack  in  1; dbus_rdata  in  32  word containing the addressed bytes.

Function
REQ-019 FSM states IDLE, BUSY, RESP; encoding in package.
REQ-020 req_ready = 1 only in IDLE; accept = req_valid & req_ready; request fields latched on accept.
REQ-021 Accept with aligned address and legal size -> BUSY; misaligned (half addr[0]=1, word addr[1:0]!=0) or size=3 -> RESP with err=1, no bus request issued.
REQ-022 BUSY: dbus_req=1; addr/wen/strobe/wdata held stable until ack; dbus_addr = {addr[ADDR_W-1:2],2'b00}.
REQ-023 dbus_ack in BUSY: capture dbus_rdata, clear wait counter, -> RESP with err=0; dbus_req drops next cycle.
REQ-024 Wait counter increments each BUSY cycle without ack; reaching MAX_WAIT -> RESP with err=1, dbus_req dropped; ack in the same cycle wins (no error).
REQ-025 RESP lasts exactly one cycle: resp_valid=1, then -> IDLE; a new request is not accepted in RESP.
REQ-026 stall = (IDLE & req_valid) | BUSY; stall=0 in RESP so upstream advances exactly once per completion.
REQ-027 Strobe: byte 4'b0001<<off, half 4'b0011<<off, word 4'b1111, off=addr[1:0]; wdata replicated: byte {4{b}}, half {2{h}}, word as-is.
REQ-028 Load data: lane = captured rdata >> (8*off); byte/half sign- or zero-extended per req_unsigned; word unchanged.
REQ-029 dbus_ack outside BUSY ignored.
REQ-030 req_valid deasserting while in BUSY does not abort the transaction.

Reset
REQ-031 resetn=0 at a clock edge: state IDLE, counter 0, latched fields 0; all outputs 0 except req_ready=1.
REQ-032 Reset mid-BUSY: dbus_req drops the following cycle, no resp_valid produced for the aborted request.

Structure
REQ-033 msize_t (MSIZE_B=0, MSIZE_H=1, MSIZE_W=2), FSM state enum, and the 4-bit strobe type in the shared pipes package.
REQ-034 One sub-module, mem_align: combinational strobe/wdata replication and load extraction/extension.

Verification
REQ-035 Word load, addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF -> stall 4 cycles, resp_valid with rdata 0xDEADBEEF, err 0.
REQ-036 Signed byte load, addr 0x103, rdata 0x80FF1234 -> resp_rdata 0xFFFFFF80; same with req_unsigned=1 -> 0x00000080.
REQ-037 Half store, addr 0x202, wdata 0x0000ABCD -> dbus_addr 0x200, strobe 4'b1100, dbus_wdata 0xABCDABCD, wen 1.
REQ-038 Word load, addr 0x101 -> no dbus_req, resp_valid next cycle with err 1, rdata 0.
REQ-039 MAX_WAIT=4, no ack -> dbus_req high 4 cycles, then resp_valid err 1; late ack ignored.
REQ-040 resetn low during BUSY -> next cycle IDLE, req_ready 1, no resp_valid; back-to-back requests afterwards complete normally.
